dmem_responder: RTL and testbench

Data-side memory responder sitting on the far end of the CPU core's data port (`mem_en`/`mem_we`/`sel`/`mem_wdata_last`/`mem_size` out, `mem_rdata`/`stallreq_from_mem` in). Holds a word-organised on-chip data RAM with a programmable number of wait states. While a request is in service it raises `stallreq_from_mem`, then returns a registered read word. Used for bring-up and simulation of the pipeline's memory-stall path before the cache/AXI path exists.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-side memory responder: word-organised on-chip RAM behind the core's data port,
// with a fixed number of wait states and a registered read word.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  sel,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  input  logic        mem_cancel,
  input  logic        ext_hold,
  output logic [31:0] mem_rdata,
  output logic        stallreq_from_mem
);

  localparam int unsigned LP_DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] LP_CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_next;

  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [3:0]              r_sel;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;

  logic [31:0]             r_mem [LP_DEPTH];

  logic                    w_req;
  logic                    w_enter_done;
  logic                    w_commit;
  logic [ADDR_WIDTH-1:0]   w_c_addr;
  logic                    w_c_we;
  logic [3:0]              w_c_sel;
  logic [31:0]             w_c_wdata;
  logic                    w_ram_we;
  logic                    w_load;
  logic                    w_unused;

  assign w_unused = ^{mem_size, mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  assign w_req = (r_state == S_IDLE) && mem_en && !mem_cancel;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LP_CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (!ext_hold) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
  assign w_commit     = w_enter_done && !rst;

  // With zero wait states the commit edge is the acceptance edge, so the
  // request is taken straight from the port instead of the latched copy.
  assign w_c_addr  = (r_state == S_IDLE) ? mem_addr[ADDR_WIDTH+1:2] : r_addr;
  assign w_c_we    = (r_state == S_IDLE) ? mem_we    : r_we;
  assign w_c_sel   = (r_state == S_IDLE) ? sel       : r_sel;
  assign w_c_wdata = (r_state == S_IDLE) ? mem_wdata : r_wdata;

  assign w_ram_we = w_commit && w_c_we;
  assign w_load   = w_commit && !w_c_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_req) begin
        r_addr  <= mem_addr[ADDR_WIDTH+1:2];
        r_we    <= mem_we;
        r_sel   <= sel;
        r_wdata <= mem_wdata;
      end
      if (w_load) begin
        r_rdata <= r_mem[w_c_addr];
      end
    end
  end

  // RAM contents survive reset; only the commit gate honours rst.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_c_sel[i]) begin
          r_mem[w_c_addr][8*i +: 8] <= w_c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata         = r_rdata;
  assign stallreq_from_mem = !rst && (w_req || (r_state == S_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        en2, we2, cancel2, hold2;
  logic [31:0] addr2, wd2;
  logic [3:0]  sel2;
  logic [1:0]  size2;
  logic [31:0] rdata2;
  logic        stall2;

  logic        en0, we0, cancel0, hold0;
  logic [31:0] addr0, wd0;
  logic [3:0]  sel0;
  logic [1:0]  size0;
  logic [31:0] rdata0;
  logic        stall0;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_en(en2), .mem_we(we2), .mem_addr(addr2), .sel(sel2),
    .mem_size(size2), .mem_wdata(wd2), .mem_cancel(cancel2), .ext_hold(hold2),
    .mem_rdata(rdata2), .stallreq_from_mem(stall2)
  );

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_en(en0), .mem_we(we0), .mem_addr(addr0), .sel(sel0),
    .mem_size(size0), .mem_wdata(wd0), .mem_cancel(cancel0), .ext_hold(hold0),
    .mem_rdata(rdata0), .stallreq_from_mem(stall0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts RAM store commits on the 2-wait-state instance.
  always @(posedge clk) if (dut.w_ram_we) wr_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request at the current point (a negedge), count stall cycles,
  // return mem_rdata from the first non-stalled cycle, then return on the next negedge.
  task automatic access(input bit which, input bit we, input logic [31:0] addr,
                        input logic [3:0] s, input logic [31:0] wd, input bit cancel,
                        output int stalls, output logic [31:0] rd);
    if (which) begin
      en0 = 1'b1; we0 = we; addr0 = addr; sel0 = s; wd0 = wd; cancel0 = cancel;
    end else begin
      en2 = 1'b1; we2 = we; addr2 = addr; sel2 = s; wd2 = wd; cancel2 = cancel;
    end
    stalls = 0;
    #1;
    while ((which ? stall0 : stall2) && stalls < 32) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd = which ? rdata0 : rdata2;
    if (which) begin
      en0 = 1'b0; cancel0 = 1'b0;
    end else begin
      en2 = 1'b0; cancel2 = 1'b0;
    end
    @(negedge clk);
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    en2 = 1'b1; we2 = 1'b0; addr2 = 32'h10; sel2 = 4'hF; size2 = 2'd2; wd2 = '0;
    cancel2 = 1'b0; hold2 = 1'b0;
    en0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = 4'hF; size0 = 2'd2; wd0 = '0;
    cancel0 = 1'b0; hold0 = 1'b0;

    @(negedge clk);
    chk("stall_in_reset", {31'd0, stall2}, 32'd0);
    @(negedge clk);
    chk("rdata_reset", rdata2, 32'h0);
    chk("rdata0_reset", rdata0, 32'h0);
    en2 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Preload through the port.
    access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, st, rd);
    chk("store_stall", 32'(st), 32'd3);
    access(0, 1, 32'h20, 4'hF, 32'hAABBCCDD, 0, st, rd);
    access(0, 1, 32'h40, 4'hF, 32'hCAFEF00D, 0, st, rd);

    access(0, 0, 32'h10, 4'hF, 32'h0, 0, st, rd);
    chk("load_stall", 32'(st), 32'd3);
    chk("load_data", rd, 32'hDEADBEEF);

    access(0, 1, 32'h20, 4'b0011, 32'h11223344, 0, st, rd);
    chk("part_store_stall", 32'(st), 32'd3);
    chk("store_keeps_rdata", rd, 32'hDEADBEEF);
    access(0, 0, 32'h20, 4'hF, 32'h0, 0, st, rd);
    chk("part_store_merge", rd, 32'hAABB3344);

    access(0, 0, 32'h10, 4'hF, 32'h0, 1, st, rd);
    chk("cancel_load_stall", 32'(st), 32'd0);
    chk("cancel_load_rdata", rd, 32'hAABB3344);
    #1;
    chk("cancel_idle_stall", {31'd0, stall2}, 32'd0);
    @(negedge clk);
    access(0, 1, 32'h20, 4'hF, 32'h0, 1, st, rd);
    chk("cancel_store_stall", 32'(st), 32'd0);
    access(0, 0, 32'h20, 4'hF, 32'h0, 0, st, rd);
    chk("after_cancel_ld_stall", 32'(st), 32'd3);
    chk("cancel_store_noop", rd, 32'hAABB3344);

    access(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0, st, rd);
    access(0, 0, 32'h20, 4'hF, 32'h0, 0, st, rd);
    chk("sel0_store_noop", rd, 32'hAABB3344);

    // Store held in DONE by ext_hold with mem_en still asserted.
    wr_cnt = 0;
    en2 = 1'b1; we2 = 1'b1; addr2 = 32'h30; sel2 = 4'hF; wd2 = 32'h00000055; hold2 = 1'b1;
    st = 0;
    #1;
    while (stall2 && st < 32) begin
      st++;
      @(negedge clk);
      #1;
    end
    chk("hold_store_stall", 32'(st), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("hold_stall_low", {31'd0, stall2}, 32'd0);
      chk("hold_rdata_stable", rdata2, 32'hAABB3344);
      if (k < 2) begin
        @(negedge clk);
        #1;
      end
    end
    hold2 = 1'b0;
    en2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_single_write", 32'(wr_cnt), 32'd1);
    access(0, 0, 32'h30, 4'hF, 32'h0, 0, st, rd);
    chk("hold_store_data", rd, 32'h00000055);

    // Zero-wait-state instance.
    access(1, 1, 32'h0, 4'hF, 32'h01020304, 0, st, rd);
    chk("w0_store_stall", 32'(st), 32'd1);
    access(1, 1, 32'h4, 4'hF, 32'hA5A55A5A, 0, st, rd);
    access(1, 0, 32'h0, 4'hF, 32'h0, 0, st, rd);
    chk("w0_load0_stall", 32'(st), 32'd1);
    chk("w0_load0_data", rd, 32'h01020304);
    access(1, 0, 32'h4, 4'hF, 32'h0, 0, st, rd);
    chk("w0_load4_stall", 32'(st), 32'd1);
    chk("w0_load4_data", rd, 32'hA5A55A5A);
    access(1, 1, 32'h4, 4'b1100, 32'h77660000, 0, st, rd);
    access(1, 0, 32'h4, 4'hF, 32'h0, 0, st, rd);
    chk("w0_store_then_load", rd, 32'h77665A5A);

    // Reset while a store sits in its last WAIT cycle.
    en2 = 1'b1; we2 = 1'b1; addr2 = 32'h40; sel2 = 4'hF; wd2 = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_pre_stall", {31'd0, stall2}, 32'd1);
    rst = 1'b1;
    en2 = 1'b0;
    #1;
    chk("rst_stall_low", {31'd0, stall2}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_rdata_cleared", rdata2, 32'h0);
    chk("rst_stall_after", {31'd0, stall2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    access(0, 0, 32'h40, 4'hF, 32'h0, 0, st, rd);
    chk("rst_store_aborted", rd, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
